// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger slice: BCD time layout,
// field slice positions and trigger FSM state encoding.
package alarm_pkg;

  localparam int unsigned HHMM_W = 13;

  // Bit positions of the hour, minute and second fields inside a 20-bit BCD time
  localparam int unsigned HH_MSB = 19;
  localparam int unsigned HH_LSB = 14;
  localparam int unsigned MM_MSB = 13;
  localparam int unsigned MM_LSB = 7;
  localparam int unsigned SS_MSB = 6;
  localparam int unsigned SS_LSB = 0;

  localparam logic [5:0] MAX_HOUR_BCD = 6'h23;

  typedef struct packed {
    logic [1:0] hh_t;
    logic [3:0] hh_u;
    logic [2:0] mm_t;
    logic [3:0] mm_u;
    logic [2:0] ss_t;
    logic [3:0] ss_u;
  } bcd_time_t;

  typedef enum logic [1:0] {
    TS_IDLE        = 2'd0,
    TS_RINGING     = 2'd1,
    TS_SNOOZE_CALC = 2'd2,
    TS_SNOOZED     = 2'd3
  } trigger_state_e;

endpackage

// File: rtl/alarm_trigger_if.sv
// Time/button/ring bundle between the timekeeper, alarm setter and alarm_trigger.
interface alarm_trigger_if;
  import alarm_pkg::*;

  logic      tick_1hz;
  bcd_time_t cur_time;
  bcd_time_t alarm_time;
  logic      alarm_en;
  logic      stop_btn;
  logic      snooze_btn;
  logic      ring;
  logic      snoozed;

  modport master (
    output tick_1hz, cur_time, alarm_time, alarm_en, stop_btn, snooze_btn,
    input  ring, snoozed
  );

  modport slave (
    input  tick_1hz, cur_time, alarm_time, alarm_en, stop_btn, snooze_btn,
    output ring, snoozed
  );
endinterface

// File: rtl/alarm_trigger_bcd_min_inc.sv
// Combinational BCD HH:MM plus one minute, wrapping 23:59 -> 00:00.
module bcd_min_inc
  import alarm_pkg::*;
(
  input  logic [HHMM_W-1:0] hhmm,
  output logic [HHMM_W-1:0] hhmm_next_c
);

  localparam int unsigned HR_HI = HH_MSB - MM_LSB;
  localparam int unsigned HR_LO = HH_LSB - MM_LSB;
  localparam int unsigned MN_HI = MM_MSB - MM_LSB;

  logic [5:0] hr;
  logic [5:0] hr_n;
  logic [6:0] mn;
  logic [6:0] mn_n;

  assign hr = hhmm[HR_HI:HR_LO];
  assign mn = hhmm[MN_HI:0];

  // Ripple carry: minute units -> minute tens -> hour
  always_comb begin
    hr_n = hr;
    mn_n = mn;
    if (mn[3:0] != 4'd9) begin
      mn_n[3:0] = 4'(mn[3:0] + 4'd1);
    end else begin
      mn_n[3:0] = 4'd0;
      if (mn[6:4] != 3'd5) begin
        mn_n[6:4] = 3'(mn[6:4] + 3'd1);
      end else begin
        mn_n[6:4] = 3'd0;
        if (hr == MAX_HOUR_BCD) begin
          hr_n = 6'd0;
        end else if (hr[3:0] == 4'd9) begin
          hr_n[3:0] = 4'd0;
          hr_n[5:4] = 2'(hr[5:4] + 2'd1);
        end else begin
          hr_n[3:0] = 4'(hr[3:0] + 4'd1);
        end
      end
    end
  end

  assign hhmm_next_c = {hr_n, mn_n};

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: rings on the rising edge of a time match, handles stop, snooze
// and ring timeout. Define ALARM_BEEP_PATTERN_EN for a 1 s on / 1 s off ring.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_MIN     = 5
) (
  input  logic            clk,
  input  logic            reset,
  alarm_trigger_if.slave  bus
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE        = TS_IDLE;
  localparam logic [1:0] S_RINGING     = TS_RINGING;
  localparam logic [1:0] S_SNOOZE_CALC = TS_SNOOZE_CALC;
  localparam logic [1:0] S_SNOOZED     = TS_SNOOZED;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic [HHMM_W-1:0] snz_tgt_q, snz_tgt_d;
  logic              prev_match_q;
  logic              ring_q, ring_d;
  logic              snoozed_q, snoozed_d;

  logic [HHMM_W-1:0] cur_hhmm_c;
  logic [HHMM_W-1:0] target_hhmm_c;
  logic [HHMM_W-1:0] snz_tgt_inc_c;
  logic              match_c;
  logic              match_rise_c;
  logic              alarm_ss_unused;

  assign cur_hhmm_c      = bus.cur_time[HH_MSB:MM_LSB];
  assign alarm_ss_unused = ^bus.alarm_time[SS_MSB:SS_LSB];

  // Compare against the snooze target only while a snooze is armed
  assign target_hhmm_c = (state_q == S_SNOOZED) ? snz_tgt_q
                                                : bus.alarm_time[HH_MSB:MM_LSB];
  assign match_c       = (cur_hhmm_c == target_hhmm_c) &&
                         (bus.cur_time[SS_MSB:SS_LSB] == 7'd0);
  assign match_rise_c  = match_c && !prev_match_q;

  bcd_min_inc u_min_inc (
    .hhmm        (snz_tgt_q),
    .hhmm_next_c (snz_tgt_inc_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    snz_cnt_d = snz_cnt_q;
    snz_tgt_d = snz_tgt_q;
    ring_d    = 1'b0;
    snoozed_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (match_rise_c) state_d = S_RINGING;
      end
      S_RINGING: begin
        if (bus.stop_btn) begin
          state_d = S_IDLE;
        end else if (bus.snooze_btn) begin
          state_d   = S_SNOOZE_CALC;
          snz_tgt_d = cur_hhmm_c;
          snz_cnt_d = CNT_W'(SNOOZE_MIN);
        end else if (bus.tick_1hz) begin
          if (tmo_q == CNT_W'(RING_TIMEOUT_S - 1)) state_d = S_IDLE;
          else                                     tmo_d   = CNT_W'(tmo_q + 1'b1);
        end
      end
      S_SNOOZE_CALC: begin
        if (bus.stop_btn) begin
          state_d = S_IDLE;
        end else begin
          snz_tgt_d = snz_tgt_inc_c;
          snz_cnt_d = CNT_W'(snz_cnt_q - 1'b1);
          if (snz_cnt_q == CNT_W'(1)) state_d = S_SNOOZED;
        end
      end
      S_SNOOZED: begin
        if (bus.stop_btn)      state_d = S_IDLE;
        else if (match_rise_c) state_d = S_RINGING;
      end
      default: state_d = S_IDLE;
    endcase

    if (!bus.alarm_en) state_d = S_IDLE;

    if ((state_d == S_RINGING) && (state_q != S_RINGING)) tmo_d = '0;

`ifdef ALARM_BEEP_PATTERN_EN
    if (state_d == S_RINGING) begin
      if (state_q != S_RINGING) ring_d = 1'b1;
      else if (bus.tick_1hz)    ring_d = !ring_q;
      else                      ring_d = ring_q;
    end
`else
    ring_d = (state_d == S_RINGING);
`endif

    snoozed_d = (state_d == S_SNOOZE_CALC) || (state_d == S_SNOOZED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      snz_cnt_q    <= '0;
      snz_tgt_q    <= '0;
      prev_match_q <= 1'b0;
      ring_q       <= 1'b0;
      snoozed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      snz_cnt_q    <= snz_cnt_d;
      snz_tgt_q    <= snz_tgt_d;
      prev_match_q <= match_c;
      ring_q       <= ring_d;
      snoozed_q    <= snoozed_d;
    end
  end

  assign bus.ring    = ring_q;
  assign bus.snoozed = snoozed_q;

endmodule
